shift_normalizer: RTL and testbench
===================================

# shift_normalizer

- Multi-cycle normalizer: the inverse of the barrel shifter.
- Given a 32-bit operand, it computes the left-shift amount that normalizes the operand, and returns the normalized value.
- Consumes an operand under a start/busy/done handshake and resolves one binary-search stage (16/8/4/2/1) per cycle.
- Serves the datapath's count-leading-zeros / count-leading-sign-bits operations and the normalize step of software-assisted multiply/divide.

## Interface
Parameters: none (width fixed at 32).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when idle
- a  input  32  operand; captured on the accepted start edge
- ctrl  input  1  0 = count leading zeros (CLZ); 1 = count redundant sign bits (CLS); captured with a
- busy  output  1  high while a computation is in flight
- done  output  1  one-cycle pulse; results valid
- shamt  output  6  normalize amount, 0..32
- res  output  32  a << shamt (logical, zero fill)
- zero  output  1  CLZ mode and a == 0

One clock; reset is asynchronous and active-low.

## Operation
- Idle state: busy = 0.
  - start = 1 at a rising edge captures a and ctrl into the working registers, clears the count, and enters RUN.
- RUN state: stages k = 4,3,2,1,0, one per cycle, in that order.
  - CLZ test: the top 2^k bits of the working value are all 0.
  - CLS test: the top 2^k bits below bit 31 all equal the captured a[31].
  - Test true: shift the working value left by 2^k and add 2^k to the count.
- After stage 0:
  - CLZ: if the working value is 0, shamt = 32 and res = 0. Otherwise shamt = count.
  - CLS: shamt = count, range 0..31.
  - Go to DONE.
- DONE state, one cycle: done = 1, busy = 0, then return to Idle.
  - DONE counts as idle: start in the DONE cycle is accepted.
- Result definitions:
  - CLZ shamt = number of leading 0 bits of a.
  - CLS shamt = number of bits below bit 31 equal to a[31], counted contiguously from bit 30.
  - res = a << shamt in both modes.
- shamt, res and zero hold their last values until the next accepted start, then update only at DONE.
- start while busy = 1 is ignored; a and ctrl changes during RUN have no effect.
- Reset (rst_n = 0), asserted at any time including mid-RUN:
  - Aborts immediately and returns to Idle.
  - busy = 0, done = 0, shamt = 0, res = 0, zero = 0.
  - No done pulse for the aborted operation.

## Timing
- Start accepted at edge E0.
- busy = 1 for the 5 cycles after E0, one stage per cycle at edges E1..E5.
- done = 1 and results valid in the cycle following E5, i.e. 6 cycles after E0.
- Back-to-back throughput: one result every 6 cycles when start is held high.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SHIFT_NORMALIZER_CLS_EN defined: ctrl selects CLZ/CLS as above.
- Undefined:
  - CLS logic is not compiled.
  - ctrl is ignored; every operation is CLZ.
  - Latency and handshake are unchanged.

## Test plan
- CLZ, a = 0x00010000, start for one cycle -> busy 5 cycles; done 6 cycles after start edge; shamt = 15, res = 0x80000000, zero = 0.
- CLZ, a = 0x00000000 -> shamt = 32, res = 0, zero = 1. CLZ, a = 0x80000000 -> shamt = 0, res = 0x80000000.
- CLS, a = 0xFFFF8000 -> shamt = 16, res = 0x80000000. CLS, a = 0x00000001 -> shamt = 30, res = 0x40000000. CLS, a = 0xFFFFFFFF -> shamt = 31, res = 0x80000000.
- start pulsed again 2 cycles into RUN with a = 0x1 -> ignored; the first result is unchanged. start held high continuously -> done pulses every 6 cycles.
- rst_n low 3 cycles into RUN -> all outputs 0 immediately; no done pulse. A new start after release gives a correct result with normal latency.
- Build without SHIFT_NORMALIZER_CLS_EN, ctrl = 1, a = 0xFFFF8000 -> CLZ result: shamt = 0, res = 0xFFFF8000.

Source files
------------

// File: rtl/shift_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_normalizer_if
//  Description : Request/result bundle for the shift normalizer. The master
//                issues start/a/ctrl. The slave returns the handshake flags
//                and the normalize result.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_normalizer_if;
    logic        start;
    logic [31:0] a;
    logic        ctrl;
    logic        busy;
    logic        done;
    logic [5:0]  shamt;
    logic [31:0] res;
    logic        zero;

    modport master (
        output start,
        output a,
        output ctrl,
        input  busy,
        input  done,
        input  shamt,
        input  res,
        input  zero
    );

    modport slave (
        input  start,
        input  a,
        input  ctrl,
        output busy,
        output done,
        output shamt,
        output res,
        output zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_normalizer
//  Description : Multi-cycle 32-bit normalizer. It runs a binary search over
//                the stages 16/8/4/2/1, one stage per cycle, to find the left
//                shift that normalizes the operand. The outputs are the shift
//                amount and the shifted value.
//                Define SHIFT_NORMALIZER_CLS_EN to compile the
//                count-leading-sign-bits mode, which is selected by ctrl.
//                Without that define every operation is a CLZ.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_normalizer (
    input  wire                  clk,
    input  wire                  rst_n,
    shift_normalizer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] C_FIRST_STAGE = 3'd4;

    state_t      r_state;
    state_t      w_state_nx;

    logic [31:0] r_work;
    logic [5:0]  r_count;
    logic [2:0]  r_stage;

    logic [5:0]  r_shamt;
    logic [31:0] r_res;
    logic        r_zero;

`ifdef SHIFT_NORMALIZER_CLS_EN
    logic        r_cls;
    logic        r_sign;
    logic        w_cls_hit;
`endif

    logic        w_accept;
    logic        w_last;
    logic        w_clz_hit;
    logic        w_hit;
    logic        w_is_clz;
    logic [5:0]  w_amt;
    logic [31:0] w_work_nx;
    logic [5:0]  w_count_nx;
    logic        w_work_zero;

    // DONE is treated as idle, so back-to-back requests lose no cycle.
    assign w_accept = (r_state != S_RUN) && bus.start;
    assign w_last   = (r_state == S_RUN) && (r_stage == 3'd0);

`ifdef SHIFT_NORMALIZER_CLS_EN
    assign w_is_clz = ~r_cls;
`else
    assign w_is_clz = 1'b1;
`endif

    // Stage test for the current search width 2^k. For CLZ, check whether
    // the top bits are all zero. For CLS, check whether the bits just below
    // bit 31 all match the captured sign.
    always_comb begin
        w_amt     = 6'd0;
        w_clz_hit = 1'b0;
`ifdef SHIFT_NORMALIZER_CLS_EN
        w_cls_hit = 1'b0;
`endif
        case (r_stage)
            3'd4: begin
                w_amt     = 6'd16;
                w_clz_hit = (r_work[31:16] == 16'h0000);
`ifdef SHIFT_NORMALIZER_CLS_EN
                w_cls_hit = (r_work[30:15] == {16{r_sign}});
`endif
            end
            3'd3: begin
                w_amt     = 6'd8;
                w_clz_hit = (r_work[31:24] == 8'h00);
`ifdef SHIFT_NORMALIZER_CLS_EN
                w_cls_hit = (r_work[30:23] == {8{r_sign}});
`endif
            end
            3'd2: begin
                w_amt     = 6'd4;
                w_clz_hit = (r_work[31:28] == 4'h0);
`ifdef SHIFT_NORMALIZER_CLS_EN
                w_cls_hit = (r_work[30:27] == {4{r_sign}});
`endif
            end
            3'd1: begin
                w_amt     = 6'd2;
                w_clz_hit = (r_work[31:30] == 2'b00);
`ifdef SHIFT_NORMALIZER_CLS_EN
                w_cls_hit = (r_work[30:29] == {2{r_sign}});
`endif
            end
            3'd0: begin
                w_amt     = 6'd1;
                w_clz_hit = (r_work[31] == 1'b0);
`ifdef SHIFT_NORMALIZER_CLS_EN
                w_cls_hit = (r_work[30] == r_sign);
`endif
            end
            default: begin
                w_amt     = 6'd0;
                w_clz_hit = 1'b0;
            end
        endcase
    end

    // Apply the stage result. A CLS search never takes all 32 bits,
    // because bit 31 is the sign reference and is never tested.
`ifdef SHIFT_NORMALIZER_CLS_EN
    assign w_hit = r_cls ? w_cls_hit : w_clz_hit;
`else
    assign w_hit = w_clz_hit;
`endif

    assign w_work_nx   = w_hit ? (r_work << w_amt) : r_work;
    assign w_count_nx  = w_hit ? (r_count + w_amt) : r_count;
    assign w_work_zero = (w_work_nx == 32'h0000_0000);

    // State register. Reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: IDLE or DONE, then RUN for five stages, then DONE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = w_accept ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Working registers. Capture on accept, then take one search step
    // per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= 32'h0000_0000;
            r_count <= 6'd0;
            r_stage <= 3'd0;
        end else if (w_accept) begin
            r_work  <= bus.a;
            r_count <= 6'd0;
            r_stage <= C_FIRST_STAGE;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work_nx;
            r_count <= w_count_nx;
            r_stage <= r_stage - 3'd1;
        end
    end

`ifdef SHIFT_NORMALIZER_CLS_EN
    // Mode and sign reference. Both are frozen for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cls  <= 1'b0;
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_cls  <= bus.ctrl;
            r_sign <= bus.a[31];
        end
    end
`endif

    // Result registers. They load on the last stage, so they are visible
    // in the DONE cycle. Otherwise they hold their value.
    // An all-zero CLZ operand reports 32, not the search total of 31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shamt <= 6'd0;
            r_res   <= 32'h0000_0000;
            r_zero  <= 1'b0;
        end else if (w_last) begin
            r_res <= w_work_nx;
            if (w_is_clz && w_work_zero) begin
                r_shamt <= 6'd32;
                r_zero  <= 1'b1;
            end else begin
                r_shamt <= w_count_nx;
                r_zero  <= 1'b0;
            end
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    assign bus.done  = (r_state == S_DONE);
    assign bus.shamt = r_shamt;
    assign bus.res   = r_res;
    assign bus.zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_normalizer
//  Description : Directed self-checking bench for shift_normalizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_normalizer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shift_normalizer_if bus_if ();

    shift_normalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] sh, input logic [31:0] r, input logic z);
        check({tag, ".shamt"}, {26'd0, bus_if.shamt}, {26'd0, sh});
        check({tag, ".res"}, bus_if.res, r);
        check({tag, ".zero"}, {31'd0, bus_if.zero}, {31'd0, z});
    endtask

    // One operation: start for a single cycle, check busy on each RUN
    // cycle, check the done cycle and the results, then check that done
    // drops again. When ign > 0, a stray start with a = 1 is pulsed
    // that many cycles into RUN.
    task automatic run_op(input string tag, input logic [31:0] av, input logic cv,
                          input logic [5:0] sh, input logic [31:0] r, input logic z,
                          input int ign);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.ctrl  = cv;
        @(negedge clk);
        bus_if.start = 1'b0;
        check({tag, ".busy0"}, {31'd0, bus_if.busy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check({tag, ".busy"}, {31'd0, bus_if.busy}, 32'd1);
            check({tag, ".nodone"}, {31'd0, bus_if.done}, 32'd0);
            if (i == ign) begin
                bus_if.start = 1'b1;
                bus_if.a     = 32'h0000_0001;
            end else begin
                bus_if.start = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, ".done"}, {31'd0, bus_if.done}, 32'd1);
        check({tag, ".busyoff"}, {31'd0, bus_if.busy}, 32'd0);
        check_outs(tag, sh, r, z);
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, bus_if.done}, 32'd0);
        check_outs({tag, ".hold"}, sh, r, z);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = 32'h0;
        bus_if.ctrl  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst.done", {31'd0, bus_if.done}, 32'd0);
        check_outs("rst", 6'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("clz_10000", 32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0, 0);
        run_op("clz_zero",  32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1, 0);
        run_op("clz_msb",   32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0, 0);
        run_op("clz_one",   32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0, 0);
        run_op("clz_mid",   32'h0012_3456, 1'b0, 6'd11, 32'h91A2_B000, 1'b0, 0);
`ifdef SHIFT_NORMALIZER_CLS_EN
        run_op("cls_ffff8", 32'hFFFF_8000, 1'b1, 6'd16, 32'h8000_0000, 1'b0, 0);
        run_op("cls_one",   32'h0000_0001, 1'b1, 6'd30, 32'h4000_0000, 1'b0, 0);
        run_op("cls_ones",  32'hFFFF_FFFF, 1'b1, 6'd31, 32'h8000_0000, 1'b0, 0);
        run_op("cls_zero",  32'h0000_0000, 1'b1, 6'd31, 32'h0000_0000, 1'b0, 0);
        run_op("cls_none",  32'h4000_0000, 1'b1, 6'd0,  32'h4000_0000, 1'b0, 0);
`else
        run_op("clzonly",   32'hFFFF_8000, 1'b1, 6'd0,  32'hFFFF_8000, 1'b0, 0);
`endif

        // A stray start two cycles into RUN must not disturb the result.
        run_op("ignore",    32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0, 2);

        // With start held high, done pulses every 6 cycles.
        bus_if.start = 1'b1;
        bus_if.a     = 32'h0000_0100;
        bus_if.ctrl  = 1'b0;
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            check("b2b.done", {31'd0, bus_if.done}, {31'd0, (j % 6) == 5});
            if (j == 17) bus_if.start = 1'b0;
        end
        check_outs("b2b", 6'd23, 32'h8000_0000, 1'b0);
        @(negedge clk);
        check("b2b.idle", {31'd0, bus_if.busy}, 32'd0);

        // Reset three cycles into RUN clears everything at once, and
        // the aborted operation produces no done pulse.
        bus_if.start = 1'b1;
        bus_if.a     = 32'h0001_0000;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort.done", {31'd0, bus_if.done}, 32'd0);
        check_outs("abort", 6'd0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort.nodone", {31'd0, bus_if.done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.idle", {31'd0, bus_if.done}, 32'd0);
        run_op("post_rst",  32'h0000_0F00, 1'b0, 6'd20, 32'hF000_0000, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
